// File: rtl/input_controller.sv
// rtl/input_controller.sv - router input port: flit FIFO plus route/request/forward FSM
// The header flit's low bits pick the output port; packets to nonexistent ports are drained.
module input_controller #(
  parameter int NUMBER_CHANNELS = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEST_WIDTH      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_eop,
  output logic                         in_ready,
  output logic [NUMBER_CHANNELS-1:0]   req_channel,
  input  logic [NUMBER_CHANNELS-1:0]   gnt_channel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_eop,
  input  logic                         out_ack,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         err_drop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DROP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;

  logic                       push;
  logic                       pop;
  logic                       not_empty;
  logic                       head_eop;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [DEST_WIDTH-1:0]      head_dest;
  logic [NUMBER_CHANNELS-1:0] req_vec;
  logic                       granted;

  assign head_data = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_eop  = mem_q[rd_ptr_q][DATA_WIDTH];
  assign head_dest = head_data[DEST_WIDTH-1:0];

  always_comb begin
    not_empty   = (count_q != '0);
    in_ready    = !rst && (count_q != CW'(FIFO_DEPTH));
    push        = in_valid && in_ready;
    req_vec     = NUMBER_CHANNELS'(1) << dest_q;
    granted     = |(gnt_channel & req_vec);
    state_d     = state_q;
    dest_d      = dest_q;
    req_channel = '0;
    out_valid   = 1'b0;
    pop         = 1'b0;
    err_drop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          dest_d  = head_dest;
          state_d = (32'(head_dest) < NUMBER_CHANNELS) ? S_REQ : S_DROP;
        end
      end
      S_REQ: begin
        req_channel = req_vec;
        if (granted) state_d = S_XFER;
      end
      S_XFER: begin
        // A dropped grant just stalls the head flit; nothing is popped until it returns.
        req_channel = req_vec;
        out_valid   = granted && not_empty;
        pop         = out_valid && out_ack;
        if (pop && head_eop) state_d = S_IDLE;
      end
      S_DROP: begin
        pop = not_empty;
        if (pop && head_eop) begin
          err_drop = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      req_channel = '0;
      out_valid   = 1'b0;
      pop         = 1'b0;
      err_drop    = 1'b0;
    end

    out_eop    = out_valid && head_eop;
    out_data   = (rst || !not_empty) ? '0 : head_data;
    fifo_count = rst ? '0 : count_q;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_eop, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dest_q   <= dest_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_input_controller.sv
// tb/tb_input_controller.sv - directed self-checking bench for input_controller
module tb_input_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_eop;
  logic        in_ready;
  logic [4:0]  req_channel;
  logic [4:0]  gnt_channel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_eop;
  logic        out_ack;
  logic [3:0]  fifo_count;
  logic        err_drop;

  int n_checks = 0;
  int n_fail   = 0;

  logic mon_en = 1'b0;
  int   err_pulses;
  int   req_seen;
  int   ov_seen;

  input_controller #(
    .NUMBER_CHANNELS(5),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(8),
    .DEST_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_eop(in_eop),
    .in_ready(in_ready),
    .req_channel(req_channel),
    .gnt_channel(gnt_channel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_eop(out_eop),
    .out_ack(out_ack),
    .fifo_count(fifo_count),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (err_drop) err_pulses++;
      if (req_channel != 5'b0) req_seen++;
      if (out_valid) ov_seen++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic e);
    in_valid = v;
    in_data  = d;
    in_eop   = e;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    gnt_channel = 5'b0;
    out_ack = 1'b0;

    // reset values
    step(); step(); settle();
    check("rst_in_ready", in_ready, 0);
    check("rst_req", req_channel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_err_drop", err_drop, 0);
    rst = 1'b0;
    settle();
    check("post_rst_in_ready", in_ready, 1);

    // 3-flit packet to dest 2, grant two cycles after request
    out_ack = 1'b1;
    step();
    drive(1'b1, 32'hA000_0002, 1'b0);
    step(); settle();
    check("p1_req_t1", req_channel, 5'b00000);
    drive(1'b1, 32'hA000_1111, 1'b0);
    step(); settle();
    check("p1_req_t2", req_channel, 5'b00100);
    drive(1'b1, 32'hA000_2222, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    step();
    gnt_channel = 5'b00100;
    settle();
    check("p1_no_valid_before_xfer", out_valid, 0);
    step(); settle();
    check("p1_f0_valid", out_valid, 1);
    check("p1_f0_data", out_data, 32'hA000_0002);
    check("p1_f0_eop", out_eop, 0);
    step(); settle();
    check("p1_f1_data", out_data, 32'hA000_1111);
    check("p1_f1_valid", out_valid, 1);
    step(); settle();
    check("p1_f2_data", out_data, 32'hA000_2222);
    check("p1_f2_eop", out_eop, 1);
    step(); settle();
    check("p1_req_off", req_channel, 0);
    check("p1_out_valid_off", out_valid, 0);
    check("p1_count", fifo_count, 0);
    gnt_channel = 5'b0;
    out_ack = 1'b0;

    // fill to depth with no grant
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hB000_0001 + (i << 8), (i == 7));
      step();
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    settle();
    check("full_count", fifo_count, 8);
    check("full_in_ready", in_ready, 0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    settle();
    check("full_9th_rejected", fifo_count, 8);
    gnt_channel = 5'b00010;
    out_ack = 1'b1;
    step(); settle();
    check("full_head", out_data, 32'hB000_0001);
    step(); settle();
    check("after_ack_count", fifo_count, 7);
    check("after_ack_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) step();
    settle();
    check("full_last_data", out_data, 32'hB000_0701);
    check("full_last_eop", out_eop, 1);
    step(); settle();
    check("full_drained", fifo_count, 0);
    check("full_req_off", req_channel, 0);
    gnt_channel = 5'b0;
    out_ack = 1'b0;

    // invalid destination is dropped
    err_pulses = 0; req_seen = 0; ov_seen = 0;
    mon_en = 1'b1;
    drive(1'b1, 32'hC000_0006, 1'b0); step();
    drive(1'b1, 32'hC000_0010, 1'b0); step();
    drive(1'b1, 32'hC000_0020, 1'b0); step();
    drive(1'b1, 32'hC000_0030, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    mon_en = 1'b0;
    check("drop_err_pulses", err_pulses, 1);
    check("drop_req_seen", req_seen, 0);
    check("drop_out_valid_seen", ov_seen, 0);
    check("drop_count", fifo_count, 0);

    // grant withdrawn for three cycles mid-packet
    gnt_channel = 5'b01000;
    out_ack = 1'b1;
    drive(1'b1, 32'hD000_0003, 1'b0); step();
    drive(1'b1, 32'hD000_1000, 1'b0); step();
    drive(1'b1, 32'hD000_2000, 1'b0); step(); settle();
    check("stall_h_data", out_data, 32'hD000_0003);
    check("stall_h_valid", out_valid, 1);
    drive(1'b1, 32'hD000_3000, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0);
    gnt_channel = 5'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_valid_low", out_valid, 0);
      check("stall_data_held", out_data, 32'hD000_1000);
      step();
    end
    gnt_channel = 5'b01000;
    settle();
    check("resume_f1", out_data, 32'hD000_1000);
    check("resume_f1_valid", out_valid, 1);
    step(); settle();
    check("resume_f2", out_data, 32'hD000_2000);
    step(); settle();
    check("resume_f3", out_data, 32'hD000_3000);
    check("resume_f3_eop", out_eop, 1);
    step(); settle();
    check("resume_done", fifo_count, 0);
    check("resume_req_off", req_channel, 0);

    // back-to-back single-flit packets to dest 0 then dest 4
    gnt_channel = 5'b11111;
    drive(1'b1, 32'hE000_0000, 1'b1); step();
    drive(1'b1, 32'hE000_0004, 1'b1); step(); settle();
    drive(1'b0, 32'h0, 1'b0);
    check("b2b_req0", req_channel, 5'b00001);
    step(); settle();
    check("b2b_pkt0_data", out_data, 32'hE000_0000);
    check("b2b_pkt0_eop", out_eop, 1);
    step(); settle();
    check("b2b_req0_off", req_channel, 5'b00000);
    step(); settle();
    check("b2b_req4", req_channel, 5'b10000);
    step(); settle();
    check("b2b_pkt4_data", out_data, 32'hE000_0004);
    check("b2b_pkt4_eop", out_eop, 1);
    step(); settle();
    check("b2b_req4_off", req_channel, 5'b00000);

    // reset mid-packet after two flits forwarded
    gnt_channel = 5'b00010;
    drive(1'b1, 32'hF000_0001, 1'b0); step();
    drive(1'b1, 32'hF000_0100, 1'b0); step();
    drive(1'b1, 32'hF000_0200, 1'b0); step();
    drive(1'b1, 32'hF000_0300, 1'b0); step();
    drive(1'b1, 32'hF000_0400, 1'b1); settle();
    check("mid_f1_data", out_data, 32'hF000_0100);
    step();
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    settle();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_req", req_channel, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_eop", out_eop, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_err", err_drop, 0);
    step();
    rst = 1'b0;
    settle();
    check("mid_post_count", fifo_count, 0);
    check("mid_post_in_ready", in_ready, 1);
    check("mid_post_req", req_channel, 0);
    drive(1'b1, 32'h1234_5601, 1'b0); step();
    drive(1'b1, 32'h1234_5700, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0);
    step(); settle();
    check("new_pkt_h", out_data, 32'h1234_5601);
    check("new_pkt_h_valid", out_valid, 1);
    step(); settle();
    check("new_pkt_f", out_data, 32'h1234_5700);
    check("new_pkt_eop", out_eop, 1);
    step(); settle();
    check("new_pkt_done", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_controller.md
INPUT_CONTROLLER -- requirements
Module: input_controller

Interface
REQ-001 Parameter NUMBER_CHANNELS, default 5: number of switch ports; sets the width of req_channel and gnt_channel.
REQ-002 Parameter DATA_WIDTH, default 32: flit payload width.
REQ-003 Parameter FIFO_DEPTH, default 8: flit buffer depth; legal values are powers of two, 2 or more.
REQ-004 Parameter DEST_WIDTH, default 3: width of the destination port field, taken from header flit bits [DEST_WIDTH-1:0].
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_data  in  DATA_WIDTH  upstream flit.
REQ-008 in_valid  in  1  upstream flit valid.
REQ-009 in_eop  in  1  marks the last flit of a packet; qualified by in_valid.
REQ-010 in_ready  out  1  buffer can accept a flit this cycle.
REQ-011 req_channel  out  NUMBER_CHANNELS  one-hot request to the output controllers.
REQ-012 gnt_channel  in  NUMBER_CHANNELS  grant bits returned by the output controllers for this input.
REQ-013 out_data  out  DATA_WIDTH  flit at the FIFO head, sent to the crossbar.
REQ-014 out_valid  out  1  out_data is valid and granted.
REQ-015 out_eop  out  1  the flit on out_data is the last flit of its packet.
REQ-016 out_ack  in  1  downstream has accepted the flit on out_data.
REQ-017 fifo_count  out  clog2(FIFO_DEPTH)+1  number of flits currently buffered.
REQ-018 err_drop  out  1  one-cycle pulse when a packet with an invalid destination is discarded.

Function
REQ-019 FIFO: stores {eop, data}; push = in_valid & in_ready; in_ready = (fifo_count != FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
REQ-020 A push while full shall never occur, because in_ready is low; a pop while empty shall never occur, because out_valid requires a non-empty FIFO.
REQ-021 A simultaneous push and pop shall leave fifo_count unchanged; a flit written at cycle t shall be visible at the head at cycle t+1.
REQ-022 FSM states: S_IDLE, S_REQ, S_XFER, S_DROP.
REQ-023 S_IDLE: if the FIFO is non-empty, the head is a header flit; register dest_reg = head[DEST_WIDTH-1:0]; go to S_REQ if dest_reg < NUMBER_CHANNELS, else go to S_DROP.
REQ-024 req_channel = (1 << dest_reg) in S_REQ and S_XFER, and 0 in S_IDLE and S_DROP.
REQ-025 S_REQ: go to S_XFER when (gnt_channel & req_channel) != 0; otherwise hold with req asserted, with no timeout.
REQ-026 S_XFER: out_valid = granted & FIFO non-empty; out_eop = head eop bit & out_valid; pop = out_valid & out_ack.
REQ-027 S_XFER: if the grant drops mid-packet, out_valid goes low and the state holds; no flit is lost.
REQ-028 S_XFER: on the pop of the flit with eop=1, go to S_IDLE; req_channel is therefore 0 in the next cycle, so the output controller sees no request when it re-enters its idle state.
REQ-029 S_DROP: pop one flit per cycle while the FIFO is non-empty, with out_valid held at 0; on popping the eop flit, pulse err_drop for one cycle and go to S_IDLE.
REQ-030 A single-flit packet (header with eop=1) is legal; it is forwarded or dropped like any other packet.
REQ-031 Header-to-request latency: a header pushed at cycle t into an empty FIFO in S_IDLE shall cause req_channel to be asserted at cycle t+2.
REQ-032 The header flit shall be forwarded unchanged as the first flit of the packet.
REQ-033 Back-to-back packets: after returning to S_IDLE, the next header shall be processed with no extra idle cycle beyond REQ-023.

Reset
REQ-034 While rst=1 the block shall flush the FIFO (pointers and count to 0) and set the state to S_IDLE.
REQ-035 While rst=1: in_ready=0, req_channel=0, out_valid=0, out_eop=0, out_data=0, fifo_count=0, err_drop=0.
REQ-036 After rst is released: in_ready=1 in the first cycle.
REQ-037 Reset asserted mid-packet shall discard the buffered flits and the partial packet without asserting out_eop.

Verification
REQ-038 3-flit packet, header dest=2, gnt_channel=00100 returned 2 cycles after the request, out_ack always 1 -> req_channel=00100 at t+2; 3 flits on out_data in consecutive cycles, out_eop on the 3rd; req_channel=0 the next cycle.
REQ-039 Push 8 flits with out_ack=0 (DEPTH=8) -> fifo_count=8, in_ready=0; a 9th in_valid is not accepted; after 1 ack, in_ready=1 and fifo_count=7.
REQ-040 Header dest=6 (N=5), 4-flit packet -> req_channel stays 0, out_valid stays 0, 4 pops, err_drop pulses once, FSM back in S_IDLE.
REQ-041 Grant removed for 3 cycles mid-packet -> out_valid=0 for those 3 cycles, the same out_data is held, and transfer resumes with no loss or duplication.
REQ-042 Two back-to-back single-flit packets to dest 0 then dest 4 -> req_channel 00001 then 10000, each deasserted one cycle after its ack.
REQ-043 rst pulsed after 2 of 5 flits have been forwarded -> all outputs at their reset values, fifo_count=0; a new packet afterwards is forwarded correctly.
